// File: rtl/strobe_pulse_gen_if.sv
// Configuration, strobe and status bundle for strobe_pulse_gen.
// The register block / sync pins drive the master side; the pulse generator is the slave.
interface strobe_pulse_gen_if #(
   parameter int CHANNELS  = 2,
   parameter int CNT_WIDTH = 16,
   parameter int REP_WIDTH = 8
);
   logic [CHANNELS-1:0]           EXT_IN;
   logic [CHANNELS-1:0]           EN;
   logic [2*CHANNELS-1:0]         EDGE_MODE;
   logic [CHANNELS-1:0]           SW_START;
   logic [CNT_WIDTH*CHANNELS-1:0] DELAY;
   logic [CNT_WIDTH*CHANNELS-1:0] WIDTH;
   logic [REP_WIDTH*CHANNELS-1:0] REPEAT;
   logic [CHANNELS-1:0]           CLR_MISSED;
   logic [CHANNELS-1:0]           STROBE;
   logic [CHANNELS-1:0]           PULSE;
   logic [CHANNELS-1:0]           BUSY;
   logic [CHANNELS-1:0]           MISSED;
   logic [CNT_WIDTH*CHANNELS-1:0] EVENT_CNT;

   modport master (
      output EXT_IN, EN, EDGE_MODE, SW_START, DELAY, WIDTH, REPEAT, CLR_MISSED,
      input  STROBE, PULSE, BUSY, MISSED, EVENT_CNT
   );

   modport slave (
      input  EXT_IN, EN, EDGE_MODE, SW_START, DELAY, WIDTH, REPEAT, CLR_MISSED,
      output STROBE, PULSE, BUSY, MISSED, EVENT_CNT
   );
endinterface

// File: rtl/strobe_pulse_gen.sv
// Multi-channel strobe synchroniser / edge detector feeding a delayed, repeated pulse-train FSM.
// Each channel: EXT_IN -> sync -> edge -> STROBE; trigger -> IDLE/DLY/HIGH/GAP -> PULSE.
module strobe_pulse_gen #(
   parameter int CHANNELS    = 2,
   parameter int CNT_WIDTH   = 16,
   parameter int REP_WIDTH   = 8,
   parameter int SYNC_STAGES = 2
) (
   input logic               CLK,
   input logic               RST,
   strobe_pulse_gen_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DLY,
      ST_HIGH,
      ST_GAP
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [REP_WIDTH-1:0] REP_ONE = REP_WIDTH'(1);

   // Per-channel views of the flattened configuration buses
   logic [CHANNELS-1:0][CNT_WIDTH-1:0] cfg_delay;
   logic [CHANNELS-1:0][CNT_WIDTH-1:0] cfg_width;
   logic [CHANNELS-1:0][REP_WIDTH-1:0] cfg_repeat;
   logic [CHANNELS-1:0][1:0]           cfg_mode;

   assign cfg_delay  = bus.DELAY;
   assign cfg_width  = bus.WIDTH;
   assign cfg_repeat = bus.REPEAT;
   assign cfg_mode   = bus.EDGE_MODE;

   // Synchroniser chain plus one history stage per channel
   logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q;
   logic [CHANNELS-1:0]                  hist_q;
   logic [CHANNELS-1:0]                  strobe_q;
   logic [CHANNELS-1:0]                  edge_d;

   // Pulse-train state
   state_t                             state_q [CHANNELS];
   state_t                             state_d [CHANNELS];
   logic [CHANNELS-1:0][CNT_WIDTH-1:0] cnt_q,  cnt_d;
   logic [CHANNELS-1:0][CNT_WIDTH-1:0] wid_q,  wid_d;
   logic [CHANNELS-1:0][REP_WIDTH-1:0] rep_q,  rep_d;
   logic [CHANNELS-1:0][CNT_WIDTH-1:0] evt_q,  evt_d;
   logic [CHANNELS-1:0]                pulse_q, pulse_d;
   logic [CHANNELS-1:0]                busy_q,  busy_d;
   logic [CHANNELS-1:0]                missed_q, missed_d;
   logic [CHANNELS-1:0]                trig;
   logic [CHANNELS-1:0]                accept;

   // NOTE: every variable driven here gets a default first, so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      edge_d   = '0;
      trig     = '0;
      accept   = '0;
      state_d  = state_q;
      cnt_d    = cnt_q;
      wid_d    = wid_q;
      rep_d    = rep_q;
      evt_d    = evt_q;
      missed_d = missed_q;
      pulse_d  = '0;
      busy_d   = '0;

      for (int ch = 0; ch < CHANNELS; ch++) begin
         unique case (cfg_mode[ch])
            2'b00:   edge_d[ch] =  sync_q[ch][SYNC_STAGES-1] & ~hist_q[ch];
            2'b01:   edge_d[ch] = ~sync_q[ch][SYNC_STAGES-1] &  hist_q[ch];
            2'b10:   edge_d[ch] =  sync_q[ch][SYNC_STAGES-1] ^  hist_q[ch];
            default: edge_d[ch] = 1'b0;
         endcase

         trig[ch]   = bus.EN[ch] & (strobe_q[ch] | bus.SW_START[ch]);
         accept[ch] = trig[ch] && (state_q[ch] == ST_IDLE);

         // A trigger that cannot be accepted wins over a same-cycle clear
         if (trig[ch] && (state_q[ch] != ST_IDLE)) begin
            missed_d[ch] = 1'b1;
         end else if (bus.CLR_MISSED[ch]) begin
            missed_d[ch] = 1'b0;
         end

         if (accept[ch]) begin
            evt_d[ch] = evt_q[ch] + CNT_ONE;
         end

         if (!bus.EN[ch]) begin
            state_d[ch] = ST_IDLE;
            cnt_d[ch]   = '0;
            wid_d[ch]   = '0;
            rep_d[ch]   = '0;
         end else begin
            unique case (state_q[ch])
               ST_IDLE: begin
                  if (accept[ch]) begin
                     wid_d[ch] = cfg_width[ch];
                     rep_d[ch] = (cfg_repeat[ch] == '0) ? '0 : cfg_repeat[ch] - REP_ONE;
                     if (cfg_delay[ch] != '0) begin
                        state_d[ch] = ST_DLY;
                        cnt_d[ch]   = cfg_delay[ch] - CNT_ONE;
                     end else if (cfg_width[ch] != '0) begin
                        state_d[ch] = ST_HIGH;
                        cnt_d[ch]   = cfg_width[ch] - CNT_ONE;
                     end
                  end
               end
               ST_DLY: begin
                  if (cnt_q[ch] != '0) begin
                     cnt_d[ch] = cnt_q[ch] - CNT_ONE;
                  end else if (wid_q[ch] != '0) begin
                     state_d[ch] = ST_HIGH;
                     cnt_d[ch]   = wid_q[ch] - CNT_ONE;
                  end else begin
                     state_d[ch] = ST_IDLE;
                  end
               end
               ST_HIGH: begin
                  if (cnt_q[ch] != '0) begin
                     cnt_d[ch] = cnt_q[ch] - CNT_ONE;
                  end else if (rep_q[ch] != '0) begin
                     state_d[ch] = ST_GAP;
                     cnt_d[ch]   = wid_q[ch] - CNT_ONE;
                     rep_d[ch]   = rep_q[ch] - REP_ONE;
                  end else begin
                     state_d[ch] = ST_IDLE;
                  end
               end
               ST_GAP: begin
                  if (cnt_q[ch] != '0) begin
                     cnt_d[ch] = cnt_q[ch] - CNT_ONE;
                  end else begin
                     state_d[ch] = ST_HIGH;
                     cnt_d[ch]   = wid_q[ch] - CNT_ONE;
                  end
               end
               default: state_d[ch] = ST_IDLE;
            endcase
         end

         // PULSE and BUSY are registered copies of the next state, so they never glitch
         pulse_d[ch] = (state_d[ch] == ST_HIGH);
         busy_d[ch]  = (state_d[ch] != ST_IDLE);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      // NOTE: reset is synchronous and clears every register, including the small latched
      // configuration copies; there is no RAM here that would need to be left unreset.
      if (RST) begin
         sync_q   <= '0;
         hist_q   <= '0;
         strobe_q <= '0;
         cnt_q    <= '0;
         wid_q    <= '0;
         rep_q    <= '0;
         evt_q    <= '0;
         pulse_q  <= '0;
         busy_q   <= '0;
         missed_q <= '0;
         for (int ch = 0; ch < CHANNELS; ch++) begin
            state_q[ch] <= ST_IDLE;
         end
      end else begin
         for (int ch = 0; ch < CHANNELS; ch++) begin
            sync_q[ch]  <= {sync_q[ch][SYNC_STAGES-2:0], bus.EXT_IN[ch]};
            hist_q[ch]  <= sync_q[ch][SYNC_STAGES-1];
            state_q[ch] <= state_d[ch];
         end
         strobe_q <= edge_d;
         cnt_q    <= cnt_d;
         wid_q    <= wid_d;
         rep_q    <= rep_d;
         evt_q    <= evt_d;
         pulse_q  <= pulse_d;
         busy_q   <= busy_d;
         missed_q <= missed_d;
      end
   end

   assign bus.STROBE    = strobe_q;
   assign bus.PULSE     = pulse_q;
   assign bus.BUSY      = busy_q;
   assign bus.MISSED    = missed_q;
   assign bus.EVENT_CNT = evt_q;

endmodule

// File: tb/tb_strobe_pulse_gen.sv
// Directed bench for strobe_pulse_gen: a table of single-trigger trains on channel 0,
// followed by hand-written sequences for edges, MISSED, EN abort, latching, wrap and reset.
module tb_strobe_pulse_gen;

   localparam int CH = 2;
   localparam int CW = 16;
   localparam int RW = 8;

   logic CLK;
   logic RST;

   strobe_pulse_gen_if #(.CHANNELS(CH), .CNT_WIDTH(CW), .REP_WIDTH(RW)) spg_if ();

   strobe_pulse_gen #(
      .CHANNELS(CH), .CNT_WIDTH(CW), .REP_WIDTH(RW), .SYNC_STAGES(2)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (spg_if.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;
   int ev0      = 0;
   int ev1      = 0;

   // Scheduled channel-0 events inside capture(); -1 means none
   int            ev_fall   = -1;
   int            ev_en_off = -1;
   int            ev_cfg    = -1;
   logic [CW-1:0] ev_delay, ev_width;

   logic [63:0] cap_p [CH];
   logic [63:0] cap_b [CH];
   logic [63:0] cap_s [CH];
   logic [63:0] cap_m [CH];

   typedef struct {
      logic [CW-1:0] dly;
      logic [CW-1:0] wid;
      logic [RW-1:0] rep;
      logic [63:0]   exp_pulse;  // bit i = PULSE in cycle i+1 after the trigger cycle
      int            exp_busy;   // BUSY high for cycles 1..exp_busy
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_cfg(input int ch, input logic [CW-1:0] d, input logic [CW-1:0] w,
                          input logic [RW-1:0] r);
      spg_if.DELAY[ch*CW +: CW]  = d;
      spg_if.WIDTH[ch*CW +: CW]  = w;
      spg_if.REPEAT[ch*RW +: RW] = r;
   endtask

   function automatic logic [CW-1:0] evt(input int ch);
      return spg_if.EVENT_CNT[ch*CW +: CW];
   endfunction

   // Records outputs for cycles 1..n after the current cycle; SW_START is dropped after cycle 0
   task automatic capture(input int n);
      for (int c = 0; c < CH; c++) begin
         cap_p[c] = '0;
         cap_b[c] = '0;
         cap_s[c] = '0;
         cap_m[c] = '0;
      end
      for (int k = 1; k <= n; k++) begin
         tick();
         if (k == 1) spg_if.SW_START = '0;
         for (int c = 0; c < CH; c++) begin
            cap_p[c][k-1] = spg_if.PULSE[c];
            cap_b[c][k-1] = spg_if.BUSY[c];
            cap_s[c][k-1] = spg_if.STROBE[c];
            cap_m[c][k-1] = spg_if.MISSED[c];
         end
         if (k == ev_fall)   spg_if.EXT_IN[0] = 1'b0;
         if (k == ev_en_off) spg_if.EN[0]     = 1'b0;
         if (k == ev_cfg) begin
            spg_if.DELAY[0 +: CW] = ev_delay;
            spg_if.WIDTH[0 +: CW] = ev_width;
         end
      end
      ev_fall   = -1;
      ev_en_off = -1;
      ev_cfg    = -1;
   endtask

   initial begin
      vecs[0] = '{dly: 16'd0, wid: 16'd5, rep: 8'd1, exp_pulse: 64'h0000_001F, exp_busy: 5};
      vecs[1] = '{dly: 16'd3, wid: 16'd2, rep: 8'd3, exp_pulse: 64'h0000_1998, exp_busy: 13};
      vecs[2] = '{dly: 16'd0, wid: 16'd1, rep: 8'd0, exp_pulse: 64'h0000_0001, exp_busy: 1};
      vecs[3] = '{dly: 16'd4, wid: 16'd0, rep: 8'd3, exp_pulse: 64'h0000_0000, exp_busy: 4};
      vecs[4] = '{dly: 16'd0, wid: 16'd0, rep: 8'd1, exp_pulse: 64'h0000_0000, exp_busy: 0};
      vecs[5] = '{dly: 16'd1, wid: 16'd3, rep: 8'd2, exp_pulse: 64'h0000_038E, exp_busy: 10};
      vecs[6] = '{dly: 16'd2, wid: 16'd1, rep: 8'd4, exp_pulse: 64'h0000_0154, exp_busy: 9};

      RST               = 1'b1;
      spg_if.EXT_IN     = '0;
      spg_if.EN         = '1;
      spg_if.EDGE_MODE  = '1;
      spg_if.SW_START   = '0;
      spg_if.CLR_MISSED = '0;
      spg_if.DELAY      = '0;
      spg_if.WIDTH      = '0;
      spg_if.REPEAT     = '0;
      repeat (3) tick();
      check("rst_strobe", spg_if.STROBE, 0);
      check("rst_pulse",  spg_if.PULSE, 0);
      check("rst_busy",   spg_if.BUSY, 0);
      check("rst_missed", spg_if.MISSED, 0);
      check("rst_evt",    spg_if.EVENT_CNT, 0);
      RST = 1'b0;
      tick();

      // Table of software-triggered trains on channel 0
      for (int i = 0; i < 7; i++) begin
         set_cfg(0, vecs[i].dly, vecs[i].wid, vecs[i].rep);
         spg_if.SW_START[0] = 1'b1;
         capture(32);
         ev0++;
         check($sformatf("vec%0d_pulse", i), cap_p[0], vecs[i].exp_pulse);
         check($sformatf("vec%0d_busy", i), cap_b[0], (64'd1 << vecs[i].exp_busy) - 64'd1);
         check($sformatf("vec%0d_evt", i), evt(0), ev0);
      end

      // Rising edge on EXT_IN: STROBE 3 cycles later, pulse right after
      set_cfg(0, 16'd0, 16'd5, 8'd1);
      spg_if.EDGE_MODE[1:0] = 2'b00;
      tick();
      spg_if.EXT_IN[0] = 1'b1;
      capture(20);
      ev0++;
      check("rise_strobe", cap_s[0], 64'h4);
      check("rise_pulse",  cap_p[0], 64'hF8);
      check("rise_busy",   cap_b[0], 64'hF8);
      check("rise_evt",    evt(0), ev0);
      spg_if.EXT_IN[0] = 1'b0;
      capture(10);
      check("rise_mode_fall_no_strobe", cap_s[0], 0);
      check("rise_mode_fall_no_busy",   cap_b[0], 0);

      // Both-edge mode, 20-cycle strobe, WIDTH=30: second edge lands during HIGH
      set_cfg(0, 16'd0, 16'd30, 8'd1);
      spg_if.EDGE_MODE[1:0] = 2'b10;
      spg_if.EXT_IN[0] = 1'b1;
      ev_fall = 20;
      capture(40);
      ev0++;
      check("both_strobe", cap_s[0], 64'h0040_0004);
      check("both_pulse",  cap_p[0], 64'h1_FFFF_FFF8);
      check("both_missed_edge", cap_m[0][23:22], 2'b10);
      check("both_evt",    evt(0), ev0);
      spg_if.EDGE_MODE[1:0] = 2'b11;
      spg_if.CLR_MISSED[0] = 1'b1;
      tick();
      spg_if.CLR_MISSED[0] = 1'b0;
      check("clr_missed", spg_if.MISSED[0], 0);

      // Missed trigger coincident with CLR_MISSED, then a trigger in the final HIGH cycle
      set_cfg(0, 16'd0, 16'd10, 8'd1);
      spg_if.SW_START[0] = 1'b1;
      capture(3);
      ev0++;
      spg_if.SW_START[0]   = 1'b1;
      spg_if.CLR_MISSED[0] = 1'b1;
      tick();
      spg_if.SW_START[0]   = 1'b0;
      spg_if.CLR_MISSED[0] = 1'b0;
      check("set_beats_clr", spg_if.MISSED[0], 1);
      check("busy_trig_no_evt", evt(0), ev0);
      spg_if.CLR_MISSED[0] = 1'b1;
      tick();
      spg_if.CLR_MISSED[0] = 1'b0;
      check("clr_missed2", spg_if.MISSED[0], 0);
      repeat (5) tick();
      check("last_high_pulse", spg_if.PULSE[0], 1);
      spg_if.SW_START[0] = 1'b1;
      tick();
      spg_if.SW_START[0] = 1'b0;
      check("last_high_missed", spg_if.MISSED[0], 1);
      check("last_high_done",   spg_if.BUSY[0], 0);
      spg_if.CLR_MISSED[0] = 1'b1;
      tick();
      spg_if.CLR_MISSED[0] = 1'b0;

      // EN dropped mid-HIGH aborts the train; triggers while disabled are ignored
      set_cfg(0, 16'd0, 16'd10, 8'd4);
      spg_if.SW_START[0] = 1'b1;
      ev_en_off = 5;
      capture(8);
      ev0++;
      check("en_abort_pulse", cap_p[0][7:0], 8'h1F);
      check("en_abort_busy",  cap_b[0][7:0], 8'h1F);
      spg_if.SW_START[0] = 1'b1;
      tick();
      spg_if.SW_START[0] = 1'b0;
      tick();
      check("en_off_evt",    evt(0), ev0);
      check("en_off_busy",   spg_if.BUSY[0], 0);
      check("en_off_missed", spg_if.MISSED[0], 0);
      spg_if.EN[0] = 1'b1;
      tick();

      // Config change while busy: running train keeps latched values
      set_cfg(0, 16'd2, 16'd3, 8'd1);
      ev_cfg   = 1;
      ev_delay = 16'd0;
      ev_width = 16'd1;
      spg_if.SW_START[0] = 1'b1;
      capture(10);
      ev0++;
      check("latch_pulse", cap_p[0], 64'h1C);
      check("latch_busy",  cap_b[0], 64'h1F);
      spg_if.SW_START[0] = 1'b1;
      capture(4);
      ev0++;
      check("new_cfg_pulse", cap_p[0], 64'h1);
      check("new_cfg_evt",   evt(0), ev0);

      // Both channels triggered together with different settings
      set_cfg(0, 16'd1, 16'd2, 8'd2);
      set_cfg(1, 16'd0, 16'd3, 8'd1);
      spg_if.SW_START = 2'b11;
      capture(10);
      ev0++;
      ev1++;
      check("dual_ch0_pulse", cap_p[0], 64'h66);
      check("dual_ch0_busy",  cap_b[0], 64'h7F);
      check("dual_ch1_pulse", cap_p[1], 64'h7);
      check("dual_ch1_busy",  cap_b[1], 64'h7);
      check("dual_ch0_evt",   evt(0), ev0);
      check("dual_ch1_evt",   evt(1), ev1);

      // EVENT_CNT wrap on channel 1: zero-length trains accept a trigger every cycle
      set_cfg(1, 16'd0, 16'd0, 8'd1);
      spg_if.SW_START[1] = 1'b1;
      repeat (65535 - ev1) tick();
      spg_if.SW_START[1] = 1'b0;
      check("evt_all_ones", evt(1), 16'hFFFF);
      check("evt_burst_busy", spg_if.BUSY[1], 0);
      spg_if.SW_START[1] = 1'b1;
      tick();
      spg_if.SW_START[1] = 1'b0;
      check("evt_wrap", evt(1), 0);

      // Reset in the middle of a train
      set_cfg(0, 16'd0, 16'd10, 8'd2);
      spg_if.SW_START[0] = 1'b1;
      capture(3);
      check("pre_rst_pulse", spg_if.PULSE[0], 1);
      RST = 1'b1;
      tick();
      check("mid_rst_pulse",  spg_if.PULSE, 0);
      check("mid_rst_busy",   spg_if.BUSY, 0);
      check("mid_rst_evt",    spg_if.EVENT_CNT, 0);
      check("mid_rst_missed", spg_if.MISSED, 0);
      RST = 1'b0;
      tick();
      check("post_rst_busy",  spg_if.BUSY, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/strobe_pulse_gen.md
Name: strobe_pulse_gen

Overview:
Multi-channel pulse generator that replaces paired single-channel pulsers driven by hand-built R2S/FSYNC edge detectors. Each channel does the following:
- synchronises an external strobe and edge-detects it in a selectable mode;
- after a programmable delay, emits a programmable-width pulse train of programmable repeat count.
It sits between the incoming sync pins and the sequencer start inputs (seq_gen/seq_rec SEQ_EXT_START). Configuration comes from the register block.

Parameters:
CHANNELS, 2, number of independent trigger/pulse channels
CNT_WIDTH, 16, width of DELAY, WIDTH and EVENT_CNT fields
REP_WIDTH, 8, width of REPEAT field
SYNC_STAGES, 2, synchroniser flip-flops on EXT_IN (min 2)

Ports:
CLK  in  1  single clock for all logic
RST  in  1  reset, synchronous active-high
EXT_IN  in  CHANNELS  asynchronous external strobes (R2S, FSYNC, ...)
EN  in  CHANNELS  per-channel enable; low aborts and blocks triggers
EDGE_MODE  in  2*CHANNELS  per channel: 00 rising, 01 falling, 10 both, 11 external trigger off
SW_START  in  CHANNELS  one-cycle software trigger, OR-ed with the edge trigger
DELAY  in  CNT_WIDTH*CHANNELS  cycles from trigger acceptance to first pulse
WIDTH  in  CNT_WIDTH*CHANNELS  pulse high time, also low gap between repeats
REPEAT  in  REP_WIDTH*CHANNELS  pulses per trigger; 0 treated as 1
CLR_MISSED  in  CHANNELS  clears the MISSED flag
STROBE  out  CHANNELS  registered one-cycle detected edge
PULSE  out  CHANNELS  generated pulse
BUSY  out  CHANNELS  channel not idle
MISSED  out  CHANNELS  sticky: trigger arrived while busy
EVENT_CNT  out  CNT_WIDTH*CHANNELS  accepted-trigger counter, wraps

Behaviour:
- Reset (RST high at a CLK edge):
  - synchroniser, edge register, all FSMs (to IDLE), counters, STROBE, PULSE, BUSY, MISSED and EVENT_CNT go to 0.
  - RST mid-train drops PULSE the next cycle.
- Synchroniser: SYNC_STAGES FFs, then one history FF.
- STROBE:
  - Asserts for exactly 1 cycle, SYNC_STAGES+1 cycles after the EXT_IN edge.
  - Mode 10 gives one STROBE per edge.
  - Mode 11 never asserts.
- Trigger: trig = EN & (STROBE | SW_START).
- Acceptance:
  - A trigger is accepted only in IDLE.
  - On acceptance at cycle t: DELAY, WIDTH and REPEAT are latched (later changes do not affect the running train), and EVENT_CNT increments at t+1.
  - A trigger in any non-IDLE state is ignored and sets MISSED at t+1, even in the final HIGH cycle.
  - MISSED set beats CLR_MISSED in the same cycle.
- FSM per channel: IDLE -> DLY -> HIGH -> (GAP -> HIGH)* -> IDLE.
  - IDLE: on accept go to DLY if DELAY>0, else HIGH.
  - DLY: lasts exactly DELAY cycles, then HIGH.
  - HIGH: PULSE=1 for WIDTH cycles; first rising edge of PULSE at t+1+DELAY.
  - After HIGH: if pulses remaining > 0 go to GAP (PULSE=0 for WIDTH cycles), then HIGH; otherwise go to IDLE.
  - WIDTH=0: no pulse and no gap; return to IDLE directly after DLY (or at t+1).
- BUSY = (state != IDLE), registered; high from t+1 through the last HIGH cycle.
- Total busy cycles = DELAY + WIDTH*(2*REPEAT-1).
- EN low in any state: next cycle IDLE, PULSE=0, no MISSED, latched values dropped.
- Counters are CNT_WIDTH/REP_WIDTH unsigned, no overflow. A max DELAY of 2^CNT_WIDTH-1 must be exact.
- EVENT_CNT wraps from all-ones to 0.
- Channels are fully independent; a simultaneous trigger on all channels is accepted by each.
- PULSE is driven directly from a register (glitch-free).

Test Plan:
- Ch0 rising mode, DELAY=0, WIDTH=5, REPEAT=1; EXT_IN rises at cycle 10 → STROBE high at cycle 13 (SYNC_STAGES=2), PULSE high cycles 14..18, BUSY low at 19, EVENT_CNT=1.
- DELAY=3, WIDTH=2, REPEAT=3 via SW_START at cycle 0 → PULSE high cycles 4-5, 8-9, 12-13; BUSY high cycles 1..13.
- Mode 10, EXT_IN pulse 20 cycles wide → two STROBEs 20 cycles apart.
  - With WIDTH=30, second edge is ignored and MISSED=1; CLR_MISSED then clears MISSED.
  - CLR_MISSED coincident with a new missed trigger → MISSED stays 1.
- Mid-train (WIDTH=10, REPEAT=4), deassert EN at cycle 15 → PULSE=0 and BUSY=0 at 16; triggers with EN=0 leave EVENT_CNT unchanged.
- Change DELAY/WIDTH registers during BUSY → running train keeps the latched values; the next trigger uses the new values.
  - WIDTH=0 with DELAY=4 → PULSE never rises, BUSY high 4 cycles.
- Ch0 and ch1 triggered on the same cycle with different settings → independent correct trains.
  - Preload 65535 triggers then one more → EVENT_CNT=0.
  - RST mid-train → all outputs 0 next cycle.
